game_scoreboard: RTL



---
 rtl/game_scoreboard_pkg.sv | 57 +++++
 rtl/game_scoreboard_bcd.sv | 66 ++++++
 rtl/game_scoreboard.sv | 134 +++++++++++++
 3 files changed

// File: rtl/game_scoreboard_pkg.sv
// Shared constants for the game scoreboard: segment patterns, display modes
// and the double-dabble converter state encoding.
package game_scoreboard_pkg;

    // Segments are active low, bit 6 = a ... bit 0 = g.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_H     = 7'b1001000;
    localparam logic [6:0] SEG_S     = 7'b0100100;

    typedef enum logic [1:0] {
        MODE_BLANK = 2'd0,
        MODE_SCORE = 2'd1,
        MODE_HIGH  = 2'd2
    } disp_mode_e;

    typedef enum logic [1:0] {
        CONV_IDLE  = 2'd0,
        CONV_SHIFT = 2'd1,
        CONV_DONE  = 2'd2
    } conv_state_e;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    seg_digit = 7'b0000001;
            4'd1:    seg_digit = 7'b1001111;
            4'd2:    seg_digit = 7'b0010010;
            4'd3:    seg_digit = 7'b0000110;
            4'd4:    seg_digit = 7'b1001100;
            4'd5:    seg_digit = 7'b0100100;
            4'd6:    seg_digit = 7'b0100000;
            4'd7:    seg_digit = 7'b0001111;
            4'd8:    seg_digit = 7'b0000000;
            4'd9:    seg_digit = 7'b0000100;
            default: seg_digit = SEG_BLANK;
        endcase
    endfunction

    function automatic logic [6:0] mode_glyph(input disp_mode_e m);
        case (m)
            MODE_HIGH:  mode_glyph = SEG_H;
            MODE_SCORE: mode_glyph = SEG_S;
            default:    mode_glyph = SEG_BLANK;
        endcase
    endfunction

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
    function automatic logic [11:0] dd_adjust(input logic [11:0] bcd);
        logic [11:0] r;
        r = bcd;
        for (int i = 0; i < 3; i++) begin
            if (r[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/game_scoreboard_bcd.sv
// Free-running sequential binary-to-BCD converter (double dabble), one result
// every 10 cycles: latch, 8 shift steps, publish.
module bin2bcd_seq
    import game_scoreboard_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] bin,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       valid
);

    conv_state_e state, state_nxt;
    logic [7:0]  bin_sr;
    logic [11:0] bcd;
    logic [2:0]  bit_cnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= CONV_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CONV_IDLE:  state_nxt = CONV_SHIFT;
            CONV_SHIFT: if (bit_cnt == 3'd7) state_nxt = CONV_DONE;
            CONV_DONE:  state_nxt = CONV_IDLE;
            default:    state_nxt = CONV_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bin_sr   <= '0;
            bcd      <= '0;
            bit_cnt  <= '0;
            hundreds <= '0;
            tens     <= '0;
            ones     <= '0;
        end else begin
            case (state)
                CONV_IDLE: begin
                    bin_sr  <= bin;
                    bcd     <= '0;
                    bit_cnt <= '0;
                end
                CONV_SHIFT: begin
                    {bcd, bin_sr} <= {dd_adjust(bcd), bin_sr} << 1;
                    bit_cnt       <= bit_cnt + 3'd1;
                end
                CONV_DONE: begin
                    hundreds <= bcd[11:8];
                    tens     <= bcd[7:4];
                    ones     <= bcd[3:0];
                end
                default: ;
            endcase
        end
    end

    assign valid = (state == CONV_DONE);

endmodule

// File: rtl/game_scoreboard.sv
// Score tracking from the game FSM's one-hot state, value selection and
// 4-digit multiplexed seven-segment drive.
module game_scoreboard
    import game_scoreboard_pkg::*;
#(
    parameter int REFRESH_BITS = 18
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       q_Initial,
    input  logic       q_PlayInitial,
    input  logic       q_Play,
    input  logic       q_PlayDone,
    input  logic       q_Scores,
    input  logic [7:0] outputNumber,
    output logic [7:0] currentScore,
    output logic [7:0] highScore,
    output logic       newHigh,
    output logic [3:0] an,
    output logic [6:0] ssd
);

    logic prevPlay, prevPlayInit;
    logic start_ev, correct_ev, end_ev;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prevPlay     <= 1'b0;
            prevPlayInit <= 1'b0;
        end else begin
            prevPlay     <= q_Play;
            prevPlayInit <= q_PlayInitial;
        end
    end

    assign start_ev   = q_PlayInitial && !prevPlay && !prevPlayInit;
    assign correct_ev = prevPlay && q_PlayInitial;
    assign end_ev     = prevPlay && q_PlayDone;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            currentScore <= '0;
            highScore    <= '0;
            newHigh      <= 1'b0;
        end else begin
            if (q_Initial || start_ev)
                currentScore <= '0;
            else if (correct_ev && currentScore != 8'hFF)
                currentScore <= currentScore + 8'd1;

            if (start_ev)
                newHigh <= 1'b0;

            // A tie clears the flag but keeps the stored high score.
            if (end_ev) begin
                if (currentScore > highScore) begin
                    highScore <= currentScore;
                    newHigh   <= 1'b1;
                end else if (currentScore == highScore) begin
                    newHigh   <= 1'b0;
                end
            end
        end
    end

    logic [7:0] disp_val;
    disp_mode_e disp_mode;

    always_comb begin
        disp_val  = outputNumber;
        disp_mode = MODE_BLANK;
        if (q_Scores) begin
            disp_val  = highScore;
            disp_mode = MODE_HIGH;
        end else if (q_PlayDone) begin
            disp_val  = currentScore;
            disp_mode = MODE_SCORE;
        end
    end

    logic [3:0] hundreds, tens, ones;
    logic       conv_valid;
    logic       conv_ready;

    bin2bcd_seq u_bcd (
        .Clk      (Clk),
        .Reset    (Reset),
        .bin      (disp_val),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones),
        .valid    (conv_valid)
    );

    // Number digits stay dark until the first conversion after reset lands.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)           conv_ready <= 1'b0;
        else if (conv_valid) conv_ready <= 1'b1;
    end

    logic [3:0][6:0] seg_d;

    always_comb begin
        seg_d[3] = mode_glyph(disp_mode);
        seg_d[2] = SEG_BLANK;
        seg_d[1] = SEG_BLANK;
        seg_d[0] = SEG_BLANK;
        if (conv_ready) begin
            if (hundreds != 4'd0)
                seg_d[2] = seg_digit(hundreds);
            if (hundreds != 4'd0 || tens != 4'd0)
                seg_d[1] = seg_digit(tens);
            seg_d[0] = seg_digit(ones);
        end
    end

    logic [REFRESH_BITS-1:0] refreshCnt;
    logic [1:0]              sel;

    assign sel = refreshCnt[REFRESH_BITS-1 -: 2];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            refreshCnt <= '0;
            an         <= 4'b1111;
            ssd        <= SEG_BLANK;
        end else begin
            refreshCnt <= refreshCnt + 1'b1;
            an         <= ~(4'b0001 << sel);
            ssd        <= seg_d[sel];
        end
    end

endmodule
